// File: rtl/writeback_stage.sv
// Y86-64 write-back stage: W pipeline register, register-file write ports,
// RUN/STOP status tracking and a saturating retired-instruction counter.
module writeback_stage #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       M_stat,
    input  logic [3:0]       M_icode,
    input  logic [63:0]      M_valE,
    input  logic [63:0]      M_valM,
    input  logic [3:0]       M_dstE,
    input  logic [3:0]       M_dstM,
    input  logic             W_stall,
    input  logic             W_bubble,
    output logic [3:0]       dstE,
    output logic [63:0]      valE,
    output logic [3:0]       dstM,
    output logic [63:0]      valM,
    output logic [3:0]       W_stat,
    output logic [3:0]       W_icode,
    output logic [3:0]       Stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] STAT_BUB = 4'd0;
    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;
    localparam logic [3:0] ICODE_NOP = 4'd1;
    localparam logic [3:0] REG_NONE  = 4'hF;

    typedef enum logic {
        S_RUN,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_stat;
    logic [3:0]       r_icode;
    logic [63:0]      r_valE;
    logic [63:0]      r_valM;
    logic [3:0]       r_dstE;
    logic [3:0]       r_dstM;
    logic [3:0]       r_term;
    logic [CNT_W-1:0] r_retired;

    logic w_run;
    logic w_terminate;
    logic w_retire;

    assign w_run       = (r_state == S_RUN);
    assign w_terminate = w_run && ((r_stat == STAT_HLT) || (r_stat == STAT_ADR) ||
                                   (r_stat == STAT_INS));
    assign w_retire    = w_run && (r_stat == STAT_AOK) && !W_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RUN;
            r_stat    <= STAT_BUB;
            r_icode   <= ICODE_NOP;
            r_valE    <= '0;
            r_valM    <= '0;
            r_dstE    <= REG_NONE;
            r_dstM    <= REG_NONE;
            r_term    <= STAT_BUB;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_terminate) begin
                r_term <= r_stat;
            end
            if (w_retire && (r_retired != '1)) begin
                r_retired <= r_retired + 1'b1;
            end
            // W register only moves in RUN; STOP freezes it regardless of stall/bubble
            if (w_run && !W_stall) begin
                if (W_bubble) begin
                    r_stat  <= STAT_BUB;
                    r_icode <= ICODE_NOP;
                    r_valE  <= '0;
                    r_valM  <= '0;
                    r_dstE  <= REG_NONE;
                    r_dstM  <= REG_NONE;
                end else begin
                    r_stat  <= M_stat;
                    r_icode <= M_icode;
                    r_valE  <= M_valE;
                    r_valM  <= M_valM;
                    r_dstE  <= M_dstE;
                    r_dstM  <= M_dstM;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        dstE         = REG_NONE;
        dstM         = REG_NONE;
        Stat         = r_term;
        if (w_run) begin
            if (w_terminate) begin
                w_state_next = S_STOP;
            end
            if (r_stat == STAT_AOK) begin
                dstE = r_dstE;
                dstM = r_dstM;
            end
            Stat = (r_stat == STAT_BUB) ? STAT_AOK : r_stat;
        end
    end

    assign valE    = r_valE;
    assign valM    = r_valM;
    assign W_stat  = r_stat;
    assign W_icode = r_icode;
    assign halted  = (r_state == S_STOP);
    assign retired = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, saturation
// sequence, then randomized traffic against a behavioural model.
module tb_writeback_stage;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    M_stat, M_icode, M_dstE, M_dstM;
    logic [63:0]   M_valE, M_valM;
    logic          W_stall, W_bubble;
    logic [3:0]    dstE, dstM, W_stat, W_icode, Stat;
    logic [63:0]   valE, valM;
    logic          halted;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    writeback_stage #(.CNT_W(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .M_stat  (M_stat),
        .M_icode (M_icode),
        .M_valE  (M_valE),
        .M_valM  (M_valM),
        .M_dstE  (M_dstE),
        .M_dstM  (M_dstM),
        .W_stall (W_stall),
        .W_bubble(W_bubble),
        .dstE    (dstE),
        .valE    (valE),
        .dstM    (dstM),
        .valM    (valM),
        .W_stat  (W_stat),
        .W_icode (W_icode),
        .Stat    (Stat),
        .halted  (halted),
        .retired (retired)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic rst, input logic stall, input logic bub,
                         input logic [3:0] ms, input logic [3:0] mi,
                         input logic [63:0] mve, input logic [63:0] mvm,
                         input logic [3:0] mde, input logic [3:0] mdm);
        reset = rst; W_stall = stall; W_bubble = bub;
        M_stat = ms; M_icode = mi; M_valE = mve; M_valM = mvm;
        M_dstE = mde; M_dstM = mdm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, stall, bub;
        logic [3:0]  ms, mi;
        logic [63:0] mve, mvm;
        logic [3:0]  mde, mdm;
        logic [3:0]  e_wstat, e_stat;
        logic        e_halt;
        logic [3:0]  e_dste, e_dstm;
        logic [63:0] e_vale, e_valm;
        logic [3:0]  e_ret;
    } vec_t;

    function automatic vec_t mk(logic rst, logic stall, logic bub, logic [3:0] ms,
                                logic [3:0] mi, logic [63:0] mve, logic [63:0] mvm,
                                logic [3:0] mde, logic [3:0] mdm, logic [3:0] e_wstat,
                                logic [3:0] e_stat, logic e_halt, logic [3:0] e_dste,
                                logic [3:0] e_dstm, logic [63:0] e_vale,
                                logic [63:0] e_valm, logic [3:0] e_ret);
        vec_t v;
        v.rst = rst; v.stall = stall; v.bub = bub; v.ms = ms; v.mi = mi;
        v.mve = mve; v.mvm = mvm; v.mde = mde; v.mdm = mdm;
        v.e_wstat = e_wstat; v.e_stat = e_stat; v.e_halt = e_halt;
        v.e_dste = e_dste; v.e_dstm = e_dstm; v.e_vale = e_vale; v.e_valm = e_valm;
        v.e_ret = e_ret;
        return v;
    endfunction

    // Behavioural reference: W contents as plain integers, a halted flag and a count
    typedef struct {
        int unsigned stat, icode, dste, dstm;
        logic [63:0] vale, valm;
    } w_t;

    w_t          m_w;
    bit          m_halt;
    int unsigned m_term;
    int unsigned m_ret;

    function automatic w_t bubble_w();
        w_t b;
        b.stat = 0; b.icode = 1; b.dste = 15; b.dstm = 15; b.vale = '0; b.valm = '0;
        return b;
    endfunction

    task automatic model_edge();
        w_t nxt;
        if (reset) begin
            m_w = bubble_w(); m_halt = 0; m_term = 0; m_ret = 0;
        end else if (!m_halt) begin
            if (m_w.stat == 1 && !W_stall && m_ret < (1 << CW) - 1) m_ret++;
            if (m_w.stat >= 2 && m_w.stat <= 4) begin
                m_halt = 1; m_term = m_w.stat;
            end
            if (W_stall) nxt = m_w;
            else if (W_bubble) nxt = bubble_w();
            else begin
                nxt.stat = M_stat; nxt.icode = M_icode; nxt.vale = M_valE;
                nxt.valm = M_valM; nxt.dste = M_dstE; nxt.dstm = M_dstM;
            end
            m_w = nxt;
        end
    endtask

    task automatic model_check();
        bit          writes = !m_halt && m_w.stat == 1;
        int unsigned exp_stat = m_halt ? m_term : (m_w.stat == 0 ? 1 : m_w.stat);
        chk("rnd.W_stat", W_stat, m_w.stat);
        chk("rnd.W_icode", W_icode, m_w.icode);
        chk("rnd.Stat", Stat, exp_stat);
        chk("rnd.halted", halted, m_halt);
        chk("rnd.dstE", dstE, writes ? m_w.dste : 15);
        chk("rnd.dstM", dstM, writes ? m_w.dstm : 15);
        chk("rnd.valE", valE, m_w.vale);
        chk("rnd.valM", valM, m_w.valm);
        chk("rnd.retired", retired, m_ret);
    endtask

    vec_t tbl[16];

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 15, 15);

        //            rst st bu ms mi  valE      valM      dE  dM | Wst Stat h dE  dM  valE   valM    ret
        tbl[0]  = mk(1, 0, 0, 1, 7, 64'h9,    64'h9,    2,  2,   0,  1,  0, 15, 15, 0,     0,      0);
        tbl[1]  = mk(0, 0, 0, 1, 3, 64'h2A,   64'h0,    0,  15,  1,  1,  0, 0,  15, 64'h2A, 0,     0);
        tbl[2]  = mk(0, 0, 0, 1, 11, 64'h108, 64'hDEAD, 4,  3,   1,  1,  0, 4,  3,  64'h108, 64'hDEAD, 1);
        tbl[3]  = mk(0, 1, 0, 1, 6, 64'h99,   64'h11,   5,  6,   1,  1,  0, 4,  3,  64'h108, 64'hDEAD, 1);
        tbl[4]  = mk(0, 1, 0, 1, 6, 64'h99,   64'h11,   5,  6,   1,  1,  0, 4,  3,  64'h108, 64'hDEAD, 1);
        tbl[5]  = mk(0, 1, 1, 1, 6, 64'h99,   64'h11,   5,  6,   1,  1,  0, 4,  3,  64'h108, 64'hDEAD, 1);
        tbl[6]  = mk(0, 0, 0, 1, 2, 64'h33,   64'h0,    7,  15,  1,  1,  0, 7,  15, 64'h33, 0,      2);
        tbl[7]  = mk(0, 0, 1, 1, 2, 64'h44,   64'h4,    8,  8,   0,  1,  0, 15, 15, 0,     0,      3);
        tbl[8]  = mk(0, 0, 1, 1, 2, 64'h44,   64'h4,    8,  8,   0,  1,  0, 15, 15, 0,     0,      3);
        tbl[9]  = mk(0, 0, 0, 2, 0, 64'h0,    64'h0,    15, 15,  2,  2,  0, 15, 15, 0,     0,      3);
        tbl[10] = mk(0, 1, 0, 1, 3, 64'h55,   64'h0,    1,  15,  2,  2,  1, 15, 15, 0,     0,      3);
        tbl[11] = mk(0, 0, 0, 1, 3, 64'h55,   64'h0,    1,  15,  2,  2,  1, 15, 15, 0,     0,      3);
        tbl[12] = mk(1, 1, 1, 1, 3, 64'h55,   64'h0,    1,  15,  0,  1,  0, 15, 15, 0,     0,      0);
        tbl[13] = mk(0, 0, 0, 3, 5, 64'h0,    64'h77,   15, 3,   3,  3,  0, 15, 15, 0,     64'h77, 0);
        tbl[14] = mk(0, 1, 0, 1, 3, 64'h5,    64'h6,    2,  2,   3,  3,  1, 15, 15, 0,     64'h77, 0);
        tbl[15] = mk(1, 0, 0, 1, 3, 64'h5,    64'h6,    2,  2,   0,  1,  0, 15, 15, 0,     0,      0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].bub, tbl[i].ms, tbl[i].mi,
                  tbl[i].mve, tbl[i].mvm, tbl[i].mde, tbl[i].mdm);
            step();
            chk($sformatf("vec%0d.W_stat", i), W_stat, tbl[i].e_wstat);
            chk($sformatf("vec%0d.Stat", i), Stat, tbl[i].e_stat);
            chk($sformatf("vec%0d.halted", i), halted, tbl[i].e_halt);
            chk($sformatf("vec%0d.dstE", i), dstE, tbl[i].e_dste);
            chk($sformatf("vec%0d.dstM", i), dstM, tbl[i].e_dstm);
            chk($sformatf("vec%0d.valE", i), valE, tbl[i].e_vale);
            chk($sformatf("vec%0d.valM", i), valM, tbl[i].e_valm);
            chk($sformatf("vec%0d.retired", i), retired, tbl[i].e_ret);
        end

        // Back-to-back AOK instructions drive the counter into saturation
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 1, 6, 64'(i), 64'(i + 100), 4'(i % 15), 15);
            step();
            chk($sformatf("sat%0d.retired", i), retired, (i < 15) ? i : 15);
            chk($sformatf("sat%0d.dstE", i), dstE, i % 15);
        end

        drive(1, 0, 0, 0, 0, 0, 0, 15, 15);
        model_edge();
        step();
        model_check();
        for (int i = 0; i < 600; i++) begin
            int unsigned r = $urandom_range(0, 99);
            logic [3:0]  ms;
            if (r < 70) ms = 1;
            else if (r < 80) ms = 0;
            else ms = 4'($urandom_range(2, 4));
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0, ms, 4'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, 4'($urandom), 4'($urandom));
            // occasional reset needed to escape STOP and keep traffic flowing
            if (m_halt && $urandom_range(0, 7) == 0) reset = 1;
            model_edge();
            step();
            model_check();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
